s7_frame_decoder: RTL
=====================

// Module: s7_frame_decoder
// PURPOSE
//  Multi-digit seven-segment-to-hex recogniser. Accepts a frame of DIGITS segment
//  patterns over a valid/ready handshake and decodes one digit per clock through a
//  single shared lookup. Returns the packed hex value plus per-digit error flags.
//  Sits between the segment-capture front end and the number-recognition logic.
// PARAMETERS
//  DIGITS      4  digits per frame (1..16)
//  ACTIVE_LOW  1  1: a segment is lit when its bit is 0; 0: lit when its bit is 1
//  HEX_EN      1  1: glyphs A,b,C,d,E,F are legal; 0: they decode as errors
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          synchronous reset, active-high
//  in_valid      in   1          input frame valid
//  in_ready      out  1          block can accept a frame
//  in_segs       in   7*DIGITS   digit k at [7k+6:7k]; bit order {g,f,e,d,c,b,a}
//  out_valid     out  1          decoded frame valid
//  out_ready     in   1          consumer accepts the frame
//  out_value     out  4*DIGITS   digit k nibble at [4k+3:4k]
//  out_err_mask  out  DIGITS     bit k set: digit k pattern was unrecognised
//  out_err       out  1          OR of out_err_mask
// BEHAVIOUR
//  - Reset: FSM=IDLE, digit index=0, in_ready=0 during rst then 1, out_valid=0,
//    out_value=0, out_err_mask=0, out_err=0. A frame in flight is discarded.
//  - Normalisation: when ACTIVE_LOW=0, invert the pattern before lookup. The table
//    below is active-low.
//  - Table (unique, no aliasing):
//    0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000|1011000 8=0000000 9=0010000|0011000 A=0001000 b=0000011
//    C=1000110 d=0100001 E=0000110 F=0001110
//  - Any other pattern, including blank 1111111, is an error: nibble=0, mask bit=1.
//    When HEX_EN=0, A..F patterns are also errors.
//  - FSM states:
//    IDLE: in_ready=1. When in_valid=1, capture in_segs, clear the value/mask
//      accumulators and set index=0, then go to DECODE.
//    DECODE: in_ready=0. Each cycle, decode digit[index] into the accumulator and
//      increment index. After digit DIGITS-1 is written, go to HOLD.
//    HOLD: out_valid=1. out_value, out_err_mask and out_err stay stable until
//      out_ready=1, then return to IDLE.
//  - Latency: accept at edge N, out_valid asserted after edge N+DIGITS. A frame is
//    accepted at most once per DIGITS+2 cycles.
//  - out_value and out_err_mask update only on the DECODE->HOLD transition.
//    The accumulators are internal.
//  - in_segs is ignored outside IDLE; in_valid during DECODE/HOLD is not lost but is
//    not accepted either (in_ready=0).
//  - out_ready outside HOLD: no effect. out_ready held high: one cycle in HOLD.
//  - Index width is clog2(DIGITS), minimum 1. It never wraps past DIGITS-1.
//  - rst asserted in any state overrides all other inputs on that edge.
// TESTING
//  1 DIGITS=4, in_segs={0110000,0010010,1111001,1000000} -> after 4 cycles out_value
//    =16'h3510, out_err_mask=0000, out_err=0.
//  2 Digit 2=1111111 (blank), others=0000000 -> out_value=16'h8088, mask=0100, err=1.
//  3 HEX_EN=0, digit0=0001000 (A) -> nibble0=0, mask bit0=1. With HEX_EN=1 ->
//    nibble0=4'hA, mask=0.
//  4 Alternates: 1011000 -> 4'h7, 0011000 -> 4'h9. 0110000 -> 4'h3 (not E) and
//    0010000 -> 4'h9 (not A).
//  5 Backpressure: out_ready=0 for 10 cycles -> out_valid and out_value stable,
//    in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
//  6 rst pulse mid-DECODE -> next cycle out_valid=0, out_value=0, mask=0, in_ready=1.
//    A new frame then decodes correctly. ACTIVE_LOW=0 run of test 1 uses inverted
//    patterns and gives the same result.

Source files
------------

// File: rtl/s7_frame_decoder.sv
// s7_frame_decoder
//   Multi-digit seven-segment to hex recogniser. A frame of DIGITS segment
//   patterns is taken over a valid/ready handshake and decoded one digit per
//   clock through a single shared lookup. The packed hex value and the
//   per-digit error flags are held until the consumer accepts them.
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   in_valid      frame offered
//   in_ready      frame can be accepted (IDLE and not in reset)
//   in_segs       digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}
//   out_valid     decoded frame held
//   out_ready     consumer takes the held frame
//   out_value     digit k nibble at [4k+3:4k]
//   out_err_mask  bit k set: digit k pattern unrecognised (nibble forced to 0)
//   out_err       OR of out_err_mask
module s7_frame_decoder #(
    parameter int DIGITS     = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit HEX_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7*DIGITS-1:0]   in_segs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_value,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx;
    logic [DIGITS-1:0][6:0]  segs_q;
    logic [DIGITS-1:0][3:0]  val_acc, val_nxt;
    logic [DIGITS-1:0]       mask_acc, mask_nxt;
    logic [6:0]              cur;
    logic [3:0]              cur_nib;
    logic                    cur_err;

    // Lookup on an active-low pattern. Returns {err, nibble}; an error
    // always carries a zero nibble.
    function automatic logic [4:0] lookup(input logic [6:0] p);
        logic [3:0] nib;
        logic       ok;
        logic       hex;
        nib = 4'h0;
        ok  = 1'b1;
        hex = 1'b0;
        case (p)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000,
            7'b1011000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000,
            7'b0011000: nib = 4'h9;
            7'b0001000: begin nib = 4'hA; hex = 1'b1; end
            7'b0000011: begin nib = 4'hB; hex = 1'b1; end
            7'b1000110: begin nib = 4'hC; hex = 1'b1; end
            7'b0100001: begin nib = 4'hD; hex = 1'b1; end
            7'b0000110: begin nib = 4'hE; hex = 1'b1; end
            7'b0001110: begin nib = 4'hF; hex = 1'b1; end
            default:    ok = 1'b0;
        endcase
        if (!ok || (hex && !HEX_EN)) return 5'b1_0000;
        return {1'b0, nib};
    endfunction

    // Normalise to active-low so one table serves both polarities.
    assign cur = ACTIVE_LOW ? segs_q[idx] : ~segs_q[idx];

    always_comb begin
        {cur_err, cur_nib} = lookup(cur);
        val_nxt            = val_acc;
        val_nxt[idx]       = cur_nib;
        mask_nxt           = mask_acc;
        mask_nxt[idx]      = cur_err;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_d = DECODE;
            end
            DECODE: begin
                if (idx == LAST) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx          <= '0;
            segs_q       <= '0;
            val_acc      <= '0;
            mask_acc     <= '0;
            out_value    <= '0;
            out_err_mask <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        segs_q   <= in_segs;
                        val_acc  <= '0;
                        mask_acc <= '0;
                        idx      <= '0;
                    end
                end
                DECODE: begin
                    val_acc  <= val_nxt;
                    mask_acc <= mask_nxt;
                    // Outputs only change as the last digit lands; idx parks
                    // at LAST rather than wrapping.
                    if (idx == LAST) begin
                        out_value    <= val_nxt;
                        out_err_mask <= mask_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_err = |out_err_mask;

endmodule
